ibex_mem_resp_model: RTL

IBEX_MEM_RESP_MODEL -- requirements
Module: ibex_mem_resp_model

---
 rtl/ibex_mem_resp_model.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ibex_mem_resp_model.sv
// rtl/ibex_mem_resp_model.sv - Ibex-style data memory responder with in-order fixed-latency responses
//
// Ports:
//   clk, reset               sole clock (posedge); synchronous active-high reset
//   request, addr, we, be,   request channel, sampled on the edge where request & grant
//   wdata, wintg             (wintg is accepted but never stored)
//   gnt_stall                forces grant low while high
//   grant                    combinational grant
//   rvalid, rdata, rintg,    response channel; data fields are zero whenever rvalid is low
//   error
//
// Optional feature: define IBEX_MEM_RESP_MODEL_INTG_EN to drive rintg with the
// inverted SECDED(39,32) check bits of rdata; otherwise rintg is tied to zero.

module ibex_mem_resp_model #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INTG_WIDTH      = 7,
    parameter int MEM_DEPTH       = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE = 32'hFFFF_0000,
    parameter logic [ADDR_WIDTH-1:0] ERR_SIZE = 32'h100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    request,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [INTG_WIDTH-1:0]   wintg,
    input  logic                    gnt_stall,
    output logic                    grant,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [INTG_WIDTH-1:0]   rintg,
    output logic                    error
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem    [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [MAX_OUTSTANDING];
    logic                  q_err  [MAX_OUTSTANDING];
    logic [3:0]            q_cd   [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  accept;
    logic                  pop;
    logic                  in_err;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH:0]   addr_x;
    logic [ADDR_WIDTH:0]   err_lo;
    logic [ADDR_WIDTH:0]   err_hi;
    logic                  unused_wintg;

    assign unused_wintg = ^wintg;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // No bypass: a full queue keeps grant low even on the cycle its head retires.
    assign grant  = request & ~gnt_stall & ~reset & (count < CNT_W'(MAX_OUTSTANDING));
    assign accept = request & grant;

    assign idx = addr[IDX_W+1:2];

    // One extra bit so ERR_BASE + ERR_SIZE cannot wrap at the top of the address space.
    assign addr_x = {1'b0, addr};
    assign err_lo = {1'b0, ERR_BASE};
    assign err_hi = {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};
    assign in_err = (addr_x >= err_lo) && (addr_x < err_hi);

    assign push_data = (in_err | we) ? '0 : mem[idx];

    // The head countdown is stored already decremented for the accept cycle,
    // so zero means this is the RESP_LATENCY-th cycle after accept.
    assign pop = ~reset & (count != '0) & (q_cd[rd_ptr] == 4'd0);

    assign rvalid = pop;
    assign rdata  = pop ? q_data[rd_ptr] : '0;
    assign error  = pop ? q_err[rd_ptr] : 1'b0;

`ifdef IBEX_MEM_RESP_MODEL_INTG_EN
    function automatic logic [6:0] secded_inv_chk(input logic [31:0] d);
        logic [38:0] w;
        logic [6:0]  c;
        w    = {7'b0, d};
        c[0] = ^(w & 39'h00_2606_BD25);
        c[1] = ^(w & 39'h00_DEBA_8050);
        c[2] = ^(w & 39'h00_413D_89AA);
        c[3] = ^(w & 39'h00_3123_4ED1);
        c[4] = ^(w & 39'h00_C2C1_323B);
        c[5] = ^(w & 39'h00_2DCC_624C);
        c[6] = ^(w & 39'h00_9850_5586);
        return c ^ 7'h2A;
    endfunction

    assign rintg = pop ? INTG_WIDTH'(secded_inv_chk(32'(q_data[rd_ptr]))) : '0;
`else
    assign rintg = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_cd[i]   <= 4'd0;
                q_err[i]  <= 1'b0;
                q_data[i] <= '0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_cd[i] != 4'd0) begin
                    q_cd[i] <= q_cd[i] - 4'd1;
                end
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // The free slot at wr_ptr never aliases a live entry because accept needs count < MAX.
            if (accept) begin
                q_cd[wr_ptr]   <= 4'(RESP_LATENCY - 1);
                q_err[wr_ptr]  <= in_err;
                q_data[wr_ptr] <= push_data;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (accept & we & ~in_err) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            count <= count + CNT_W'(accept) - CNT_W'(pop);
        end
    end

endmodule
